// File: rtl/spkid_pipe_arbiter.sv
// spkid_pipe_arbiter
// Round-robin arbiter that lets NP neuron pools share one spike-ID pipe-out
// endpoint. Winning IDs go into a first-word-fall-through FIFO that the host
// pipe-read strobe drains.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high; overrides everything else
//   req        per-pool level request, held with its id_in until granted
//   id_in      pool i ID at [i*IDW +: IDW]
//   grant      one-hot pulse: the granted pool's ID was written last edge
//   rd_en      pipe-read strobe, pops the head word (ignored while empty)
//   rd_data    FIFO head; all-ones "no spike" sentinel while empty
//   empty      FIFO holds zero words
//   full       FIFO holds 2**AW words
//   level      current word count
//   block_cnt  saturating count of cycles where an eligible request met full
module spkid_pipe_arbiter #(
  parameter int NP  = 4,
  parameter int IDW = 16,
  parameter int AW  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NP-1:0]     req,
  input  logic [NP*IDW-1:0] id_in,
  output logic [NP-1:0]     grant,
  input  logic              rd_en,
  output logic [IDW-1:0]    rd_data,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       level,
  output logic [15:0]       block_cnt
);

  localparam int PW    = (NP > 1) ? $clog2(NP) : 1;
  localparam int DEPTH = 1 << AW;

  localparam logic [AW-1:0]  PTR_ZERO  = AW'(0);
  localparam logic [AW-1:0]  PTR_ONE   = AW'(1);
  localparam logic [AW:0]    LVL_ZERO  = (AW + 1)'(0);
  localparam logic [AW:0]    LVL_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]    LVL_FULL  = (AW + 1)'(DEPTH);
  localparam logic [PW-1:0]  LAST_RST  = PW'(NP - 1);
  localparam logic [IDW-1:0] NO_SPIKE  = {IDW{1'b1}};
  localparam logic [NP-1:0]  ONE_HOT0  = NP'(1);
  localparam logic [NP-1:0]  GRANT_0   = NP'(0);
  localparam logic [15:0]    BLK_MAX   = 16'hFFFF;
  localparam logic [15:0]    BLK_ONE   = 16'h0001;
  localparam logic [15:0]    BLK_ZERO  = 16'h0000;

  logic [IDW-1:0] mem_r [0:DEPTH-1];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW-1:0]  rd_ptr_next_s;
  logic [AW:0]    level_r;
  logic [AW:0]    level_next_s;
  logic [PW-1:0]  last_r;
  logic [PW-1:0]  winner_s;
  logic [NP-1:0]  grant_r;
  logic [NP-1:0]  grant_next_s;
  logic [NP-1:0]  eligible_s;
  logic           found_s;
  logic           win_ok_s;
  logic           rd_fire_s;
  logic           blocked_s;
  logic [IDW-1:0] wr_data_s;
  logic [IDW-1:0] rd_data_r;
  logic [IDW-1:0] rd_data_next_s;
  logic           empty_r;
  logic           full_r;
  logic [15:0]    block_cnt_r;

  // Round-robin search starting just after the last winner.
  always_comb begin
    int cand;
    cand       = 0;
    // A pool still holding req during its grant cycle must not be written twice.
    eligible_s = req & ~grant_r;
    winner_s   = last_r;
    found_s    = 1'b0;
    for (int k = 1; k <= NP; k++) begin
      cand = (int'(last_r) + k) % NP;
      if (!found_s && eligible_s[cand]) begin
        winner_s = PW'(cand);
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
    win_ok_s     = found_s & ~full_r;
    blocked_s    = found_s & full_r;
    wr_data_s    = id_in[int'(winner_s)*IDW +: IDW];
    grant_next_s = win_ok_s ? (ONE_HOT0 << winner_s) : GRANT_0;
  end

  // Next read pointer, level and FIFO head (with write-through bypass).
  always_comb begin
    rd_fire_s     = rd_en & ~empty_r;
    rd_ptr_next_s = rd_fire_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    case ({win_ok_s, rd_fire_s})
      2'b10:   level_next_s = level_r + LVL_ONE;
      2'b01:   level_next_s = level_r - LVL_ONE;
      default: level_next_s = level_r;
    endcase
    // The just-written word is the new head only when it is the sole word.
    if (level_next_s == LVL_ZERO) begin
      rd_data_next_s = NO_SPIKE;
    end else if (win_ok_s && (wr_ptr_r == rd_ptr_next_s)) begin
      rd_data_next_s = wr_data_s;
    end else begin
      rd_data_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // FIFO storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && win_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data_s;
    end
  end

  // Pointers, flags, grant, arbitration history and blocked-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      level_r     <= LVL_ZERO;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      grant_r     <= GRANT_0;
      last_r      <= LAST_RST;
      rd_data_r   <= NO_SPIKE;
      block_cnt_r <= BLK_ZERO;
    end else begin
      if (win_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
        last_r   <= winner_s;
      end
      rd_ptr_r  <= rd_ptr_next_s;
      level_r   <= level_next_s;
      empty_r   <= (level_next_s == LVL_ZERO);
      full_r    <= (level_next_s == LVL_FULL);
      grant_r   <= grant_next_s;
      rd_data_r <= rd_data_next_s;
      if (blocked_s && (block_cnt_r != BLK_MAX)) begin
        block_cnt_r <= block_cnt_r + BLK_ONE;
      end
    end
  end

  assign grant     = grant_r;
  assign rd_data   = rd_data_r;
  assign empty     = empty_r;
  assign full      = full_r;
  assign level     = level_r;
  assign block_cnt = block_cnt_r;

endmodule

// File: tb/tb_spkid_pipe_arbiter.sv
// Self-checking bench for spkid_pipe_arbiter: a table of directed vectors
// followed by hand-written full/backpressure, reset and streaming sequences.
module tb_spkid_pipe_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] id_in;
  logic [3:0]  grant;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        empty;
  logic        full;
  logic [10:0] level;
  logic [15:0] block_cnt;

  int checks = 0;
  int errors = 0;

  spkid_pipe_arbiter #(.NP(4), .IDW(16), .AW(10)) dut (
    .clk(clk), .reset(reset), .req(req), .id_in(id_in), .grant(grant),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .level(level), .block_cnt(block_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        rd;
    logic [63:0] ids;
    logic [3:0]  g;
    logic [10:0] lvl;
    logic        emp;
    logic [15:0] rdd;
  } vec_t;

  vec_t vt [21];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sbq [$];
    logic [15:0] cur_id [4];
    logic [15:0] exp_head;
    int seq;
    int wr_cnt;

    localparam logic [63:0] IDS_S  = 64'h0000_0025_0000_0000;
    localparam logic [63:0] IDS_A  = 64'h0013_0012_0011_0010;
    localparam logic [63:0] IDS_R9 = 64'h0000_0022_0000_0000;
    localparam logic [63:0] IDS_R  = 64'h0033_0032_0031_0030;
    localparam logic [63:0] IDS_Z  = 64'h0000_0000_0000_0000;

    //             rst   req      rd    ids     grant    lvl     emp   rd_data
    vt[0]  = '{1'b1, 4'b0000, 1'b0, IDS_Z,  4'b0000, 11'd0, 1'b1, 16'hFFFF};
    vt[1]  = '{1'b0, 4'b0100, 1'b0, IDS_S,  4'b0100, 11'd1, 1'b0, 16'h0025};
    vt[2]  = '{1'b0, 4'b0000, 1'b1, IDS_S,  4'b0000, 11'd0, 1'b1, 16'hFFFF};
    vt[3]  = '{1'b1, 4'b0000, 1'b0, IDS_Z,  4'b0000, 11'd0, 1'b1, 16'hFFFF};
    vt[4]  = '{1'b0, 4'b1111, 1'b0, IDS_A,  4'b0001, 11'd1, 1'b0, 16'h0010};
    vt[5]  = '{1'b0, 4'b1110, 1'b0, IDS_A,  4'b0010, 11'd2, 1'b0, 16'h0010};
    vt[6]  = '{1'b0, 4'b1100, 1'b0, IDS_A,  4'b0100, 11'd3, 1'b0, 16'h0010};
    vt[7]  = '{1'b0, 4'b1000, 1'b0, IDS_A,  4'b1000, 11'd4, 1'b0, 16'h0010};
    vt[8]  = '{1'b0, 4'b0000, 1'b1, IDS_A,  4'b0000, 11'd3, 1'b0, 16'h0011};
    vt[9]  = '{1'b0, 4'b0000, 1'b1, IDS_A,  4'b0000, 11'd2, 1'b0, 16'h0012};
    vt[10] = '{1'b0, 4'b0000, 1'b1, IDS_A,  4'b0000, 11'd1, 1'b0, 16'h0013};
    vt[11] = '{1'b0, 4'b0000, 1'b1, IDS_A,  4'b0000, 11'd0, 1'b1, 16'hFFFF};
    vt[12] = '{1'b0, 4'b0000, 1'b1, IDS_A,  4'b0000, 11'd0, 1'b1, 16'hFFFF};
    vt[13] = '{1'b0, 4'b0100, 1'b0, IDS_R9, 4'b0100, 11'd1, 1'b0, 16'h0022};
    vt[14] = '{1'b0, 4'b1101, 1'b0, IDS_R,  4'b1000, 11'd2, 1'b0, 16'h0022};
    vt[15] = '{1'b0, 4'b1101, 1'b0, IDS_R,  4'b0001, 11'd3, 1'b0, 16'h0022};
    vt[16] = '{1'b0, 4'b1101, 1'b0, IDS_R,  4'b0100, 11'd4, 1'b0, 16'h0022};
    vt[17] = '{1'b0, 4'b1101, 1'b0, IDS_R,  4'b1000, 11'd5, 1'b0, 16'h0022};
    vt[18] = '{1'b0, 4'b1101, 1'b0, IDS_R,  4'b0001, 11'd6, 1'b0, 16'h0022};
    vt[19] = '{1'b0, 4'b0000, 1'b1, IDS_R,  4'b0000, 11'd5, 1'b0, 16'h0033};
    vt[20] = '{1'b0, 4'b0000, 1'b1, IDS_R,  4'b0000, 11'd4, 1'b0, 16'h0030};

    reset = 1'b1;
    req   = 4'b0000;
    rd_en = 1'b0;
    id_in = IDS_Z;
    step();
    step();
    chk("reset level", 32'(level), 32'd0);
    chk("reset empty", 32'(empty), 32'd1);
    chk("reset full", 32'(full), 32'd0);
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset block_cnt", 32'(block_cnt), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'h0000FFFF);

    for (int i = 0; i < 21; i++) begin
      reset = vt[i].rst;
      req   = vt[i].req;
      rd_en = vt[i].rd;
      id_in = vt[i].ids;
      step();
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(vt[i].g));
      chk($sformatf("v%0d level", i), 32'(level), 32'(vt[i].lvl));
      chk($sformatf("v%0d empty", i), 32'(empty), 32'(vt[i].emp));
      chk($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(vt[i].rdd));
    end

    // Fill to 1024 words: two pools alternate, giving one write per cycle.
    rd_en = 1'b0;
    req   = 4'b0011;
    id_in = 64'h0000_0000_0051_0050;
    for (int n = 0; n < 1100 && !full; n++) step();
    req = 4'b0000;
    chk("fill full", 32'(full), 32'd1);
    chk("fill level", 32'(level), 32'd1024);
    chk("fill block_cnt", 32'(block_cnt), 32'd0);
    chk("fill head", 32'(rd_data), 32'h30);
    step();
    chk("idle grant", 32'(grant), 32'd0);
    req = 4'b0010;
    repeat (5) step();
    chk("blocked block_cnt", 32'(block_cnt), 32'd5);
    chk("blocked grant", 32'(grant), 32'd0);
    chk("blocked level", 32'(level), 32'd1024);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("drain1 level", 32'(level), 32'd1023);
    chk("drain1 full", 32'(full), 32'd0);
    chk("drain1 grant", 32'(grant), 32'd0);
    chk("drain1 block_cnt", 32'(block_cnt), 32'd6);
    chk("drain1 head", 32'(rd_data), 32'h32);
    step();
    chk("refill grant", 32'(grant), 32'b0010);
    chk("refill level", 32'(level), 32'd1024);
    chk("refill full", 32'(full), 32'd1);
    req = 4'b0000;
    step();

    // Reset in the middle of traffic with requests pending.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req   = 4'b0011;
    id_in = 64'h0000_0000_0041_0040;
    repeat (7) step();
    chk("pre-reset level", 32'(level), 32'd7);
    chk("pre-reset grant", 32'(grant), 32'b0001);
    reset = 1'b1;
    step();
    chk("midrst level", 32'(level), 32'd0);
    chk("midrst empty", 32'(empty), 32'd1);
    chk("midrst full", 32'(full), 32'd0);
    chk("midrst grant", 32'(grant), 32'd0);
    chk("midrst block_cnt", 32'(block_cnt), 32'd0);
    chk("midrst rd_data", 32'(rd_data), 32'h0000FFFF);
    reset = 1'b0;
    step();
    chk("post-reset grant", 32'(grant), 32'b0001);
    chk("post-reset level", 32'(level), 32'd1);
    chk("post-reset rd_data", 32'(rd_data), 32'h40);

    // Stream 1500 writes with random concurrent reads; pointers wrap.
    req   = 4'b0000;
    reset = 1'b1;
    step();
    reset     = 1'b0;
    cur_id[0] = 16'd0;
    cur_id[1] = 16'd1;
    cur_id[2] = 16'd0;
    cur_id[3] = 16'd0;
    seq       = 2;
    wr_cnt    = 0;
    id_in     = {cur_id[3], cur_id[2], cur_id[1], cur_id[0]};
    for (int cyc = 0; cyc < 20000 && (wr_cnt < 1500 || !empty); cyc++) begin
      req   = (wr_cnt < 1500) ? 4'b0011 : 4'b0000;
      rd_en = !empty && ($urandom_range(0, 3) != 0);
      if (rd_en) begin
        exp_head = (sbq.size() > 0) ? sbq.pop_front() : 16'hFFFF;
        chk("stream rd_data", 32'(rd_data), 32'(exp_head));
      end
      step();
      for (int p = 0; p < 4; p++) begin
        if (grant[p]) begin
          sbq.push_back(cur_id[p]);
          cur_id[p] = 16'(seq);
          seq++;
          wr_cnt++;
        end
      end
      id_in = {cur_id[3], cur_id[2], cur_id[1], cur_id[0]};
    end
    rd_en = 1'b0;
    req   = 4'b0000;
    chk("stream writes done", 32'(wr_cnt >= 1500), 32'd1);
    chk("stream end level", 32'(level), 32'd0);
    chk("stream end empty", 32'(empty), 32'd1);
    chk("stream leftover", 32'(sbq.size()), 32'd0);
    chk("stream end rd_data", 32'(rd_data), 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
